// File: rtl/busca_sequenciador_pkg.sv
// Shared definitions for the multicycle RISC-V datapath: sequencing state codes,
// instruction format codes, fault codes and the NOP word.
package busca_sequenciador_pkg;

  typedef enum logic [2:0] {
    BUSCA   = 3'b000,
    DECOD   = 3'b001,
    EXEC    = 3'b010,
    MEM     = 3'b011,
    ESCRITA = 3'b100,
    PARADA  = 3'b111
  } estado_t;

  localparam logic [2:0] TIPO_I  = 3'b000;
  localparam logic [2:0] TIPO_S  = 3'b010;
  localparam logic [2:0] TIPO_R  = 3'b011;
  localparam logic [2:0] TIPO_SB = 3'b110;

  typedef enum logic [1:0] {
    ERRO_NENHUM      = 2'b00,
    ERRO_TIMEOUT     = 2'b01,
    ERRO_DESALINHADO = 2'b10,
    ERRO_TIPO        = 2'b11
  } erro_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] PASSO_PC = 32'd4;

  function automatic logic alvo_desalinhado(input logic [31:0] alvo);
    return alvo[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/busca_sequenciador_temporizador.sv
// Fetch wait counter: counts consecutive unacknowledged request cycles and flags
// the cycle in which the count would reach TIMEOUT.
module temporizador_busca #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ativo,
  input  logic ack,
  output logic estouro
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      contagem <= '0;
    end else if (!ativo || ack) begin
      contagem <= '0;
    end else begin
      contagem <= contagem + W'(1);
    end
  end

  // An ack in the final cycle suppresses the overflow, so a late ack still wins.
  assign estouro = ativo && !ack && (contagem == W'(TIMEOUT - 1));

endmodule

// File: rtl/busca_sequenciador.sv
// Instruction fetch and cycle sequencer: owns the PC, fetches over a req/ack port
// and drives the shared estado bus that qualifies every datapath stage.
module busca_sequenciador
  import busca_sequenciador_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  tipo,
  input  logic        desvio_valido,
  input  logic [31:0] desvio_alvo,
  output logic [31:0] instrucao,
  output logic [31:0] pc,
  output logic [2:0]  estado,
  output logic [1:0]  erro,
  output logic [31:0] instr_count
);

  estado_t     estado_q, estado_d;
  erro_t       erro_q, erro_d;
  logic [31:0] pc_d, instrucao_d, count_d;
  logic [31:0] pc_seq;
  logic        aceito, estouro, retira;

  assign mem_req  = (estado_q == BUSCA) && rst_n;
  assign mem_addr = pc;
  assign aceito   = mem_req && mem_ack;
  assign pc_seq   = pc + PASSO_PC;

  temporizador_busca #(
    .TIMEOUT (TIMEOUT)
  ) u_temporizador (
    .clk     (clk),
    .rst_n   (rst_n),
    .ativo   (mem_req),
    .ack     (mem_ack),
    .estouro (estouro)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    estado_d    = estado_q;
    erro_d      = erro_q;
    pc_d        = pc;
    instrucao_d = instrucao;
    retira      = 1'b0;

    unique case (estado_q)
      BUSCA: begin
        if (aceito) begin
          instrucao_d = mem_rdata;
          estado_d    = DECOD;
        end else if (estouro) begin
          erro_d   = ERRO_TIMEOUT;
          estado_d = PARADA;
        end
      end

      DECOD: estado_d = EXEC;

      EXEC: begin
        case (tipo)
          TIPO_I, TIPO_S: estado_d = MEM;
          TIPO_R:         estado_d = ESCRITA;
          TIPO_SB: begin
            if (desvio_valido && alvo_desalinhado(desvio_alvo)) begin
              erro_d   = ERRO_DESALINHADO;
              estado_d = PARADA;
            end else begin
              estado_d = BUSCA;
              retira   = 1'b1;
              pc_d     = desvio_valido ? desvio_alvo : pc_seq;
            end
          end
          default: begin
            erro_d   = ERRO_TIPO;
            estado_d = PARADA;
          end
        endcase
      end

      MEM: begin
        // Loads continue to write-back; stores retire straight from here.
        if (tipo == TIPO_S) begin
          estado_d = BUSCA;
          retira   = 1'b1;
          pc_d     = pc_seq;
        end else begin
          estado_d = ESCRITA;
        end
      end

      ESCRITA: begin
        estado_d = BUSCA;
        retira   = 1'b1;
        pc_d     = pc_seq;
      end

      PARADA: estado_d = PARADA;

      default: estado_d = PARADA;
    endcase
  end

  assign count_d = retira ? instr_count + 32'd1 : instr_count;

  // NOTE: state registers use non-blocking assignments so all of them sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q    <= BUSCA;
      erro_q      <= ERRO_NENHUM;
      pc          <= PC_RESET;
      instrucao   <= NOP;
      instr_count <= '0;
    end else begin
      estado_q    <= estado_d;
      erro_q      <= erro_d;
      pc          <= pc_d;
      instrucao   <= instrucao_d;
      instr_count <= count_d;
    end
  end

  assign estado = estado_q;
  assign erro   = erro_q;

endmodule
